// File: rtl/palette_stream_reader.sv
// palette_stream_reader: raster timing generator that pops RGB888 pixels from the palette FIFO.
// Latency: outputs registered on the edge that begins phase 0 of each pixel slot; pixelReq is high for phase 0 only.
// Backpressure: none upstream; an empty FIFO during an active RUN pixel outputs black and sets the sticky underflow flag.
//
// Ports:
//   clk_pixel, rst (async, active-low)
//   enable         - 1 streams from the FIFO, 0 returns to IDLE (black output, no pops)
//   fifoData       - FIFO head (first-word-fall-through), bufferSize / bufferEmpty - FIFO status
//   clearUnderflow - synchronous clear of underflow (a new underflow in the same cycle wins)
//   pixelReq       - pop pulse, rgbOut / de / hsync / vsync / xCount / yCount - aligned video outputs
//   frameStart     - one-cycle pulse on phase 0 of pixel (0,0), underflow - sticky starvation flag
module palette_stream_reader #(
  parameter int unsigned H_ACTIVE       = 1280,
  parameter int unsigned H_FP           = 110,
  parameter int unsigned H_SYNC         = 40,
  parameter int unsigned H_BP           = 220,
  parameter int unsigned V_ACTIVE       = 720,
  parameter int unsigned V_FP           = 5,
  parameter int unsigned V_SYNC         = 5,
  parameter int unsigned V_BP           = 20,
  parameter bit          SYNC_POL       = 1'b1,
  parameter int unsigned CLKS_PER_PIXEL = 2,
  parameter int unsigned PREFILL        = 16
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] fifoData,
  input  logic [7:0]  bufferSize,
  input  logic        bufferEmpty,
  input  logic        clearUnderflow,
  output logic        pixelReq,
  output logic [23:0] rgbOut,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] xCount,
  output logic [10:0] yCount,
  output logic        frameStart,
  output logic        underflow
);

  localparam int unsigned H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL_I > 2047) begin : g_bad_h_total
    $error("palette_stream_reader: horizontal parameter sum exceeds 2047");
  end
  if (V_TOTAL_I > 2047) begin : g_bad_v_total
    $error("palette_stream_reader: vertical parameter sum exceeds 2047");
  end
  if (CLKS_PER_PIXEL < 2 || CLKS_PER_PIXEL > 15) begin : g_bad_cpp
    $error("palette_stream_reader: CLKS_PER_PIXEL must be in 2..15");
  end

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL_I - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL_I - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  PH_LAST  = 4'(CLKS_PER_PIXEL - 1);
  localparam logic [7:0]  PREFILL_B = 8'(PREFILL);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FILL = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Raster position of the slot that the next edge begins (nx/ny/phase);
  // the visible xCount/yCount copies are only loaded on phase-0 edges.
  state_t      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [10:0] nx_q, nx_d;
  logic [10:0] ny_q, ny_d;

  logic        preq_q, preq_d;
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        fs_q, fs_d;
  logic        uf_q, uf_d;

  logic slot_start;
  logic at_origin;
  logic active;
  logic fill_ok;
  logic streaming;
  logic pop;
  logic starve;

  always_comb begin
    slot_start = (phase_q == 4'd0);
    at_origin  = (nx_q == 11'd0) && (ny_q == 11'd0);
    active     = (nx_q < H_ACT) && (ny_q < V_ACT);
    fill_ok    = (bufferSize >= PREFILL_B);
    // WAIT_FILL enters RUN on the frame-start slot itself, so that slot already streams.
    streaming  = enable && ((state_q == ST_RUN) ||
                            ((state_q == ST_WAIT_FILL) && at_origin && fill_ok));
    pop        = slot_start && streaming && active && !bufferEmpty;
    starve     = slot_start && streaming && active && bufferEmpty;

    state_d = state_q;
    phase_d = phase_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    rgb_d   = rgb_q;
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    x_d     = x_q;
    y_d     = y_q;
    uf_d    = uf_q;

    // Raster counters free-run independently of enable and state.
    if (phase_q == PH_LAST) begin
      phase_d = 4'd0;
      if (nx_q == H_LAST) begin
        nx_d = 11'd0;
        ny_d = (ny_q == V_LAST) ? 11'd0 : ny_q + 11'd1;
      end else begin
        nx_d = nx_q + 11'd1;
      end
    end else begin
      phase_d = phase_q + 4'd1;
    end

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_FILL;
        ST_WAIT_FILL: if (slot_start && at_origin && fill_ok) state_d = ST_RUN;
        default:      state_d = ST_RUN;
      endcase
    end

    // Pulses drop on every non-phase-0 edge, giving one rising edge per pop.
    preq_d = pop;
    fs_d   = slot_start && at_origin;

    if (slot_start) begin
      x_d   = nx_q;
      y_d   = ny_q;
      de_d  = active;
      hs_d  = ((nx_q >= HS_START) && (nx_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = ((ny_q >= VS_START) && (ny_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
      // Head is captured on the same edge that raises pixelReq, before the FIFO advances.
      rgb_d = pop ? fifoData : 24'h0;
    end

    if (starve) begin
      uf_d = 1'b1;
    end else if (clearUnderflow) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= 4'd0;
      nx_q    <= 11'd0;
      ny_q    <= 11'd0;
      preq_q  <= 1'b0;
      rgb_q   <= 24'h0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      x_q     <= 11'd0;
      y_q     <= 11'd0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      preq_q  <= preq_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign pixelReq   = preq_q;
  assign rgbOut     = rgb_q;
  assign de         = de_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign xCount     = x_q;
  assign yCount     = y_q;
  assign frameStart = fs_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_palette_stream_reader.sv
// tb_palette_stream_reader: small-raster bench for palette_stream_reader with a FIFO model.
// Every clock is compared against a slot-level reference model; extra frame-level and corner sequences.
// The FIFO pops on each observed pixelReq pulse; bufferSize is driven independently of the queue.
module tb_palette_stream_reader;

  localparam int CPP = 2;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 8 pixels per line
  localparam int VT = VA + VF + VS + VB;   // 6 lines per frame
  localparam int FRAME = HT * VT * CPP;    // 96 clocks per frame
  localparam int PRE = 16;

  localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] fifoData = 24'h0;
  logic [7:0]  bufferSize = 8'd0;
  logic        bufferEmpty = 1'b1;
  logic        clearUnderflow = 1'b0;
  logic        pixelReq;
  logic [23:0] rgbOut;
  logic        de, hsync, vsync;
  logic [10:0] xCount, yCount;
  logic        frameStart, underflow;

  always #5 clk_pixel = ~clk_pixel;

  palette_stream_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .CLKS_PER_PIXEL(CPP), .PREFILL(PRE)
  ) dut (
    .clk_pixel(clk_pixel), .rst(rst), .enable(enable), .fifoData(fifoData),
    .bufferSize(bufferSize), .bufferEmpty(bufferEmpty), .clearUnderflow(clearUnderflow),
    .pixelReq(pixelReq), .rgbOut(rgbOut), .de(de), .hsync(hsync), .vsync(vsync),
    .xCount(xCount), .yCount(yCount), .frameStart(frameStart), .underflow(underflow)
  );

  typedef struct packed {
    logic        preq;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        uf;
  } obs_t;

  typedef struct {
    logic       en;
    logic [7:0] size;
    int         fill;
    int         pops;
    bit         uf;
    int         de_c;
    int         hs_c;
    int         vs_c;
  } vec_t;

  int   n_assert = 0;
  int   n_fail = 0;
  int   k;          // edges since reset release
  int   mst;        // model streaming mode
  obs_t e;          // expected outputs after the next edge
  obs_t rst_obs;
  int   pop_cnt, de_cnt, hs_cnt, vs_cnt;
  logic force_empty = 1'b0;
  logic [23:0] q[$];
  vec_t tbl[6];

  function automatic obs_t cur_obs();
    obs_t o;
    o.preq = pixelReq; o.rgb = rgbOut; o.de = de; o.hs = hsync; o.vs = vsync;
    o.x = xCount; o.y = yCount; o.fs = frameStart; o.uf = underflow;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fifo_update();
    if (q.size() > 0) fifoData = q[0];
    else fifoData = 24'h0;
    bufferEmpty = (q.size() == 0) || force_empty;
  endtask

  task automatic fill_q(input int n, input logic [23:0] base);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(base + 24'(i));
    fifo_update();
  endtask

  // Reference: from the edge count derive the pixel slot and raster position,
  // then apply the streaming rules for that slot.
  task automatic predict();
    int  phase, slot, x, y;
    bit  act, origin, set_uf;
    phase  = k % CPP;
    slot   = k / CPP;
    x      = slot % HT;
    y      = (slot / HT) % VT;
    act    = (x < HA) && (y < VA);
    origin = (x == 0) && (y == 0);
    set_uf = 1'b0;
    e.preq = 1'b0;
    if (phase == 0) begin
      e.x   = 11'(x);
      e.y   = 11'(y);
      e.de  = act;
      e.hs  = (x >= HA + HF) && (x < HA + HF + HS);
      e.vs  = (y >= VA + VF) && (y < VA + VF + VS);
      e.fs  = origin;
      e.rgb = 24'h0;
      if (!enable) begin
        mst = M_IDLE;
      end else begin
        if (mst == M_WAIT && origin && bufferSize >= 8'(PRE)) mst = M_RUN;
        else if (mst == M_IDLE) mst = M_WAIT;
        if (mst == M_RUN && act) begin
          if (!bufferEmpty) begin
            e.preq = 1'b1;
            e.rgb  = fifoData;
          end else begin
            set_uf = 1'b1;
          end
        end
      end
    end else begin
      e.fs = 1'b0;
      if (!enable) mst = M_IDLE;
      else if (mst == M_IDLE) mst = M_WAIT;
    end
    if (set_uf) e.uf = 1'b1;
    else if (clearUnderflow) e.uf = 1'b0;
    k++;
  endtask

  task automatic tick();
    obs_t a;
    logic [23:0] junk;
    predict();
    @(posedge clk_pixel);
    #1;
    a = cur_obs();
    n_assert++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model_k%0d: got %h, expected %h", k - 1, a, e);
    end
    if (pixelReq) begin
      pop_cnt++;
      if (q.size() > 0) junk = q.pop_front();
      fifo_update();
    end
    if (de) de_cnt++;
    if (hsync) hs_cnt++;
    if (vsync) vs_cnt++;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  // Called mid-cycle; holds reset for 2 time units, well clear of the next edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_state", 64'(cur_obs()), 64'(rst_obs));
    k = 0; mst = M_IDLE; e = rst_obs;
    pop_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [23:0] got[$];
    int guard;

    rst_obs = '0;   // SYNC_POL=1, so idle sync level is 0
    e = rst_obs; k = 0; mst = M_IDLE;
    pop_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;

    // Frame-level vectors over 3 frames from reset (frame 1 is spent in IDLE->WAIT_FILL).
    tbl[0] = '{1'b0, 8'd20, 24, 0,  1'b0, 72, 72, 48};
    tbl[1] = '{1'b1, 8'd20, 24, 24, 1'b0, 72, 72, 48};
    tbl[2] = '{1'b1, 8'd20, 12, 12, 1'b1, 72, 72, 48};
    tbl[3] = '{1'b1, 8'd3,  24, 0,  1'b0, 72, 72, 48};
    tbl[4] = '{1'b1, 8'd16, 24, 24, 1'b0, 72, 72, 48};
    tbl[5] = '{1'b1, 8'd15, 24, 0,  1'b0, 72, 72, 48};

    #2;
    for (int i = 0; i < 6; i++) begin
      enable = tbl[i].en;
      bufferSize = tbl[i].size;
      fill_q(tbl[i].fill, 24'h000001);
      do_reset();
      repeat (3 * FRAME) tick();
      check($sformatf("vec%0d_pops", i), 64'(pop_cnt), 64'(tbl[i].pops));
      check($sformatf("vec%0d_underflow", i), 64'(underflow), 64'(tbl[i].uf));
      check($sformatf("vec%0d_de_clks", i), 64'(de_cnt), 64'(tbl[i].de_c));
      check($sformatf("vec%0d_hsync_clks", i), 64'(hs_cnt), 64'(tbl[i].hs_c));
      check($sformatf("vec%0d_vsync_clks", i), 64'(vs_cnt), 64'(tbl[i].vs_c));
    end

    // Raster-order pixel values 1..12 in the first streaming frame.
    enable = 1'b1; bufferSize = 8'd20;
    fill_q(12, 24'h000001);
    do_reset();
    repeat (FRAME) tick();
    got.delete();
    repeat (FRAME) begin
      tick();
      if (de && ((k - 1) % CPP == 0)) got.push_back(rgbOut);
    end
    check("stream_pixel_count", 64'(got.size()), 64'd12);
    for (int i = 0; i < got.size() && i < 12; i++)
      check($sformatf("stream_px%0d", i), 64'(got[i]), 64'(i + 1));

    // Late fill: bufferSize below PREFILL at first chance, at PREFILL on the next frame.
    bufferSize = 8'd3;
    fill_q(24, 24'h000A00);
    do_reset();
    repeat (2 * FRAME) tick();
    check("waitfill_no_pops", 64'(pop_cnt), 64'd0);
    bufferSize = 8'd16;
    tick();
    check("waitfill_start_pop", 64'(pixelReq), 64'd1);
    check("waitfill_start_rgb", 64'(rgbOut), 64'h000A00);

    // Underflow at pixel (2,1), hold, clear, then set-beats-clear.
    bufferSize = 8'd20;
    fill_q(40, 24'h000100);
    do_reset();
    run_to(FRAME + 2 * (1 * HT + 2));
    force_empty = 1'b1; fifo_update();
    tick();
    check("uf_rgb_black", 64'(rgbOut), 64'h0);
    check("uf_no_pop", 64'(pixelReq), 64'd0);
    check("uf_set", 64'(underflow), 64'd1);
    force_empty = 1'b0; fifo_update();
    repeat (4) tick();
    check("uf_held", 64'(underflow), 64'd1);
    clearUnderflow = 1'b1;
    tick();
    clearUnderflow = 1'b0;
    check("uf_cleared", 64'(underflow), 64'd0);
    run_to(FRAME + 2 * (2 * HT));
    force_empty = 1'b1; clearUnderflow = 1'b1; fifo_update();
    tick();
    check("uf_set_beats_clear", 64'(underflow), 64'd1);
    force_empty = 1'b0; clearUnderflow = 1'b0; fifo_update();
    tick();

    // Enable dropped for pixel x=2 of a streaming line.
    fill_q(40, 24'h000200);
    do_reset();
    run_to(FRAME + 2 * 2);
    enable = 1'b0;
    tick();
    check("disable_rgb_black", 64'(rgbOut), 64'h0);
    check("disable_no_pop", 64'(pixelReq), 64'd0);
    check("disable_x_still_2", 64'(xCount), 64'd2);
    pop_cnt = 0;
    run_to(2 * FRAME);
    check("disable_no_more_pops", 64'(pop_cnt), 64'd0);

    // Reset asserted while pixelReq is high.
    enable = 1'b1;
    fill_q(40, 24'h000300);
    do_reset();
    run_to(FRAME);
    guard = 0;
    while (!pixelReq && guard < 40) begin
      tick();
      guard++;
    end
    check("preq_high_before_reset", 64'(pixelReq), 64'd1);
    do_reset();
    tick();
    check("post_reset_x", 64'(xCount), 64'd0);
    check("post_reset_y", 64'(yCount), 64'd0);
    check("post_reset_framestart", 64'(frameStart), 64'd1);

    // Randomized traffic against the model.
    enable = 1'b1; bufferSize = 8'd20;
    fill_q(8, 24'h000400);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 150 == 0) enable = ~enable;
      if ($urandom % 40 == 0) bufferSize = 8'($urandom_range(0, 31));
      if ($urandom % 3 == 0 && q.size() < 64) q.push_back(24'($urandom));
      force_empty = ($urandom % 12 == 0);
      clearUnderflow = ($urandom % 25 == 0);
      fifo_update();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_stream_reader.md
# palette_stream_reader

Consumer end of the palette FIFO: generates video raster timing and issues pixel-request pulses that pop RGB888 entries from the palette pixel buffer. It sits between the palette stage's FIFO read port (`hdmiReadData`, `bufferSize`, `bufferEmpty`, `clk_pixelReq`) and the HDMI encoder. It produces registered RGB, data-enable and sync outputs, and reports FIFO underflow.

## Interface
- `H_ACTIVE`, 1280, active pixels per line
- `H_FP`, 110, horizontal front porch (pixels)
- `H_SYNC`, 40, hsync width (pixels)
- `H_BP`, 220, horizontal back porch (pixels)
- `V_ACTIVE`, 720, active lines
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vsync width (lines)
- `V_BP`, 20, vertical back porch (lines)
- `SYNC_POL`, 1, active level of hsync/vsync
- `CLKS_PER_PIXEL`, 2, clk_pixel cycles per pixel slot; legal values 2..15
- `PREFILL`, 16, minimum bufferSize at frame start before streaming begins
- `clk_pixel  in  1  block clock; all logic on rising edge`
- `rst  in  1  asynchronous, active-low reset`
- `enable  in  1  1 = stream from FIFO; 0 = output black, no pops`
- `fifoData  in  24  FIFO head entry (first-word-fall-through), RGB888`
- `bufferSize  in  8  FIFO occupancy`
- `bufferEmpty  in  1  1 = FIFO empty`
- `clearUnderflow  in  1  synchronous clear of the underflow flag`
- `pixelReq  out  1  pop pulse, drives FIFO clk_pixelReq; one pop per rising edge`
- `rgbOut  out  24  pixel colour to encoder`
- `de  out  1  data enable (active region)`
- `hsync  out  1  horizontal sync`
- `vsync  out  1  vertical sync`
- `xCount  out  11  current horizontal position`
- `yCount  out  11  current vertical position`
- `frameStart  out  1  one-cycle pulse on phase 0 of pixel (0,0)`
- `underflow  out  1  sticky: active pixel encountered empty FIFO while RUN`

## Operation
- Phase counter 0..CLKS_PER_PIXEL-1. xCount advances when phase wraps. xCount wraps at H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and yCount increments on that wrap. yCount wraps at V_TOTAL. Raster counters run regardless of `enable` and state.
- Active region: xCount<H_ACTIVE and yCount<V_ACTIVE.
- hsync = SYNC_POL for xCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else !SYNC_POL. vsync uses the same rule on yCount with V_ parameters, evaluated for the whole line.
- States:
  - IDLE: no pops, rgbOut=0. Goes to WAIT_FILL when `enable`=1.
  - WAIT_FILL: no pops, rgbOut=0. At phase 0 of pixel (0,0), if bufferSize>=PREFILL, goes to RUN for that same pixel. Otherwise stays in WAIT_FILL until the next frame start.
  - RUN: on phase 0 of each active pixel:
    - If !bufferEmpty: pixelReq=1 and rgbOut latches fifoData.
    - If bufferEmpty: pixelReq=0, rgbOut=0, underflow set. State stays RUN, with no skip or re-align.
- `enable`=0 in any state forces IDLE on the next edge. Raster timing continues.
- Blanking: rgbOut=0, de=0, no pops.
- underflow: set has priority over clearUnderflow in the same cycle. Otherwise clearUnderflow=1 clears it.
- Width rules: all counters are 11-bit unsigned. Parameter sums must be <=2047 (elaboration assertion). Comparison `bufferSize>=PREFILL` is 8-bit unsigned.

## Timing
- All outputs are registered and update on the clk_pixel edge that begins phase 0 of a pixel slot, except pixelReq.
- pixelReq is high exactly during phase 0 of a popping slot and low for phases 1..CLKS_PER_PIXEL-1. This guarantees one clean rising edge per pop. Maximum pop rate is one per CLKS_PER_PIXEL cycles.
- rgbOut samples fifoData on the same edge that raises pixelReq, so the head value is captured before the FIFO advances. The FIFO must present the new head within CLKS_PER_PIXEL-1 cycles.
- de, hsync, vsync, xCount, yCount and rgbOut are mutually aligned, with zero skew between them.
- Reset values:
  - pixelReq=0, rgbOut=0, de=0, underflow=0, frameStart=0.
  - hsync=vsync=!SYNC_POL.
  - xCount=yCount=0, phase=0, state IDLE.
- The first frameStart after reset deassertion occurs on the first phase-0 edge at (0,0), i.e. the first clock edge.
- Reset mid-line: all state clears immediately (asynchronous). A pixelReq high at reset drops low with no extra pop.

## Test plan
- Small raster (H 4/1/2/1, V 3/1/1/1, CLKS_PER_PIXEL=2, SYNC_POL=1), enable=0 -> period 16 clocks/line, 96/frame; hsync high at x=5,6; vsync high for y=4; de high 12 pixels/frame; zero pixelReq.
- enable=1, bufferSize=20, FIFO preloaded 0x000001..0x00000C -> RUN at frame start; 12 pixelReq pulses per frame, each 1 clock wide; rgbOut shows 0x000001..0x00000C in raster order aligned with de.
- enable=1, bufferSize=3 (<PREFILL=16) at frame start -> remains WAIT_FILL all frame, rgbOut=0, no pops; bufferSize=16 at next frame start -> streaming begins at (0,0).
- RUN with bufferEmpty=1 at pixel (2,1) -> rgbOut=0 at that pixel, no pulse, underflow=1 and held; clearUnderflow pulse -> underflow=0; simultaneous new underflow and clear -> underflow=1.
- Drop enable mid-active-line at x=2 -> next edge IDLE, rgbOut=0, no further pops; timing unchanged.
- Assert rst low while pixelReq=1 -> all outputs immediately at reset values; after release, xCount=yCount=0 and frameStart pulses.
